// File: rtl/fft_seq_pkg.sv
// Shared types for the FFT frame sequencer. MAG_SQUARED_EN selects the
// squared-magnitude datapath (wider MAG_W) instead of the |re|+|im| estimate.
package fft_seq_pkg;

    typedef enum logic [2:0] {LOAD, START, WAIT, DRAIN, REPORT} state_t;

`ifdef MAG_SQUARED_EN
    localparam int MAG_W = 33;
`else
    localparam int MAG_W = 17;
`endif

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;

    // -32768 has no positive twin in 16 bits, so it clamps to 32767
    function automatic logic [15:0] abs_sat(input logic signed [15:0] v);
        if (v == 16'sh8000)
            return 16'd32767;
        else if (v[15])
            return 16'(-v);
        else
            return 16'(v);
    endfunction

endpackage

// File: rtl/fft_bin_mag.sv
// Magnitude of one FFT bin. MAG_SQUARED_EN: re^2+im^2 with one register stage;
// otherwise a combinational |re|+|im| with saturated abs.
module fft_bin_mag
    import fft_seq_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_bin,
    input  complex_t          i_x,
    output logic              o_vld,
    output logic [ADDR_W-1:0] o_bin,
    output logic [MAG_W-1:0]  o_mag
);

    logic signed [15:0] w_re;
    logic signed [15:0] w_im;
    assign w_re = i_x.re;
    assign w_im = i_x.im;

`ifdef MAG_SQUARED_EN
    logic signed [31:0] w_re2;
    logic signed [31:0] w_im2;
    logic               r_vld;
    logic [ADDR_W-1:0]  r_bin;
    logic [MAG_W-1:0]   r_mag;

    assign w_re2 = w_re * w_re;
    assign w_im2 = w_im * w_im;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vld <= 1'b0;
            r_bin <= '0;
            r_mag <= '0;
        end else begin
            r_vld <= i_vld;
            r_bin <= i_bin;
            r_mag <= MAG_W'($unsigned(w_re2)) + MAG_W'($unsigned(w_im2));
        end
    end

    assign o_vld = r_vld;
    assign o_bin = r_bin;
    assign o_mag = r_mag;
`else
    logic w_unused;
    assign w_unused = i_clk ^ i_reset;

    assign o_vld = i_vld;
    assign o_bin = i_bin;
    assign o_mag = MAG_W'(abs_sat(w_re)) + MAG_W'(abs_sat(w_im));
`endif

endmodule

// File: rtl/fft_frame_sequencer.sv
// Loads N samples into the FFT, starts it, drains the bins and reports the
// peak-magnitude bin. Magnitude flavour is chosen by MAG_SQUARED_EN.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int N       = 512,
    parameter int ADDR_W  = 9,
    parameter int MIN_BIN = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [15:0]       i_sample_in,
    input  logic              i_sample_valid,
    output logic              o_sample_ready,
    output logic              o_load,
    output logic [ADDR_W-1:0] o_load_address,
    output logic [31:0]       o_data_in,
    output logic              o_start,
    input  logic              i_done,
    input  logic [31:0]       i_data_out,
    output logic [ADDR_W-1:0] o_peak_bin,
    output logic [MAG_W-1:0]  o_peak_mag,
    output logic              o_result_valid
);

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] BIN_MIN = ADDR_W'(MIN_BIN);
    localparam logic [ADDR_W-1:0] BIN_HI  = ADDR_W'(N / 2);

    state_t            r_state, w_next;
    logic              r_active;
    logic              r_drained;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_run_bin, r_peak_bin;
    logic [MAG_W-1:0]  r_run_mag, r_peak_mag;

    logic              w_xfer, w_take, w_in_load;
    logic              w_mag_vld, w_elig, w_first;
    logic [ADDR_W-1:0] w_mag_bin, w_base_bin, w_new_bin;
    logic [MAG_W-1:0]  w_mag, w_base_mag, w_new_mag;

    fft_bin_mag #(.ADDR_W(ADDR_W)) u_mag (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_vld   (w_take),
        .i_bin   (r_cnt),
        .i_x     (complex_t'(i_data_out)),
        .o_vld   (w_mag_vld),
        .o_bin   (w_mag_bin),
        .o_mag   (w_mag)
    );

    always_comb begin
        w_next = r_state;
        w_xfer = 1'b0;
        w_take = 1'b0;
        case (r_state)
            LOAD: begin
                if (r_active && i_sample_valid) begin
                    w_xfer = 1'b1;
                    if (r_cnt == LAST) w_next = START;
                end
            end
            START: w_next = WAIT;
            WAIT: begin
                if (i_done) begin
                    w_take = 1'b1;
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_drained && i_done) w_take = 1'b1;
                // drained flag keeps a pipelined last bin from reading as an abort
                if (w_mag_vld && w_mag_bin == LAST) w_next = REPORT;
                else if (!r_drained && !i_done) w_next = LOAD;
            end
            REPORT: w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    // bin 0 restarts the search so a stale running peak never leaks across frames
    assign w_first    = (w_mag_bin == '0);
    assign w_base_bin = w_first ? BIN_MIN : r_run_bin;
    assign w_base_mag = w_first ? '0 : r_run_mag;
    assign w_elig     = (w_mag_bin >= BIN_MIN) && (w_mag_bin < BIN_HI);
    assign w_new_bin  = (w_elig && w_mag > w_base_mag) ? w_mag_bin : w_base_bin;
    assign w_new_mag  = (w_elig && w_mag > w_base_mag) ? w_mag : w_base_mag;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= LOAD;
            r_active   <= 1'b0;
            r_drained  <= 1'b0;
            r_cnt      <= '0;
            r_run_bin  <= '0;
            r_run_mag  <= '0;
            r_peak_bin <= '0;
            r_peak_mag <= '0;
        end else begin
            r_active  <= 1'b1;
            r_state   <= w_next;
            r_drained <= (w_next == DRAIN) ? (r_drained | (w_take && r_cnt == LAST)) : 1'b0;
            if (w_xfer || w_take)
                r_cnt <= r_cnt + 1'b1;
            else if (w_next == LOAD && r_state != LOAD)
                r_cnt <= '0;
            if (w_mag_vld) begin
                r_run_bin <= w_new_bin;
                r_run_mag <= w_new_mag;
            end
            if (r_state == DRAIN && w_next == REPORT) begin
                r_peak_bin <= w_new_bin;
                r_peak_mag <= w_new_mag;
            end
        end
    end

    assign w_in_load      = r_active && (r_state == LOAD);
    assign o_sample_ready = w_in_load;
    assign o_load         = w_in_load;
    assign o_load_address = w_in_load ? r_cnt : '0;
    assign o_data_in      = w_in_load ? {i_sample_in, 16'h0000} : 32'h0;
    assign o_start        = (r_state == START);
    assign o_result_valid = (r_state == REPORT);
    assign o_peak_bin     = r_peak_bin;
    assign o_peak_mag     = r_peak_mag;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench: loads frames, plays an FFT model back with scenario tables,
// and checks the reported peak plus load/start/abort/reset corner cases.
module tb_fft_frame_sequencer;
    import fft_seq_pkg::*;

    localparam int N = 512;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             sample_ready, load, start, result_valid;
    logic [8:0]       load_address, peak_bin;
    logic [31:0]      data_in;
    logic             done = 1'b0;
    logic [31:0]      data_out = '0;
    logic [MAG_W-1:0] peak_mag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_frame_sequencer #(.N(N), .ADDR_W(9), .MIN_BIN(1)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_sample_in(sample_in), .i_sample_valid(sample_valid), .o_sample_ready(sample_ready),
        .o_load(load), .o_load_address(load_address), .o_data_in(data_in), .o_start(start),
        .i_done(done), .i_data_out(data_out),
        .o_peak_bin(peak_bin), .o_peak_mag(peak_mag), .o_result_valid(result_valid)
    );

    typedef struct {
        int bin[3];
        int re[3];
        int im[3];
        int bg_re;
        int bg_im;
        int exp_bin;
        int exp_mag;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bin_val(input vec_t v, input int k);
        logic [15:0] r, i;
        r = 16'(v.bg_re);
        i = 16'(v.bg_im);
        for (int j = 0; j < 3; j++)
            if (v.bin[j] == k) begin
                r = 16'(v.re[j]);
                i = 16'(v.im[j]);
            end
        return {r, i};
    endfunction

    task automatic load_frame(input bit toggle);
        int cnt = 0, cyc = 0, bad_rdy = 0, bad_addr = 0, bad_start = 0, bad_data = 0;
        while (cnt < N && cyc < 4000) begin
            @(negedge clk);
            if (sample_ready !== 1'b1) bad_rdy++;
            if (load_address !== 9'(cnt)) bad_addr++;
            if (start !== 1'b0) bad_start++;
            sample_valid = toggle ? cyc[0] : 1'b1;
            sample_in = 16'(cnt * 7 + 3);
            #1;
            if (load && data_in !== {sample_in, 16'h0000}) bad_data++;
            if (sample_valid) cnt++;
            cyc++;
        end
        chk("load_done_in_budget", cnt, N);
        chk("ready_during_load", bad_rdy, 0);
        chk("addr_tracks_transfers", bad_addr, 0);
        chk("no_early_start", bad_start, 0);
        chk("data_in_packing", bad_data, 0);
        @(negedge clk);
        sample_valid = 1'b0;
        chk("start_pulse", start, 1);
        chk("load_low_in_start", load, 0);
        chk("ready_low_in_start", sample_ready, 0);
        @(negedge clk);
        chk("start_one_cycle", start, 0);
    endtask

    task automatic run_frame(input vec_t v, input bit toggle, input int nbins);
        int bad_rv = 0;
        logic [8:0] old_bin;
        logic [MAG_W-1:0] old_mag;
        old_bin = peak_bin;
        old_mag = peak_mag;
        load_frame(toggle);
        repeat (3) @(negedge clk);
        chk("wait_outputs_low", {load, start, sample_ready}, 0);
        for (int k = 0; k < nbins; k++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) bad_rv++;
            done = 1'b1;
            data_out = bin_val(v, k);
        end
        @(negedge clk);
        done = 1'b0;
        data_out = '0;
        chk("no_early_result", bad_rv, 0);
        if (nbins == N) begin
            chk("result_valid_latency", result_valid, 1);
            chk("peak_bin", peak_bin, v.exp_bin);
            chk("peak_mag", peak_mag, v.exp_mag);
            @(negedge clk);
            chk("result_valid_pulse", result_valid, 0);
            chk("back_to_load", sample_ready, 1);
        end else begin
            chk("abort_no_result", result_valid, 0);
            @(negedge clk);
            chk("abort_no_result2", result_valid, 0);
            chk("abort_back_to_load", sample_ready, 1);
            chk("abort_keeps_bin", peak_bin, old_bin);
            chk("abort_keeps_mag", peak_mag, old_mag);
        end
    endtask

    initial begin
        tbl[0] = '{bin: '{37, 37, 37}, re: '{1000, 1000, 1000}, im: '{-500, -500, -500},
                   bg_re: 10, bg_im: 10, exp_bin: 37, exp_mag: 1500};
        tbl[1] = '{bin: '{20, 40, 40}, re: '{300, 300, 300}, im: '{0, 0, 0},
                   bg_re: 0, bg_im: 0, exp_bin: 20, exp_mag: 300};
        tbl[2] = '{bin: '{0, 300, 5}, re: '{32767, -32768, 100}, im: '{32767, 0, 0},
                   bg_re: 0, bg_im: 0, exp_bin: 5, exp_mag: 100};
        tbl[3] = '{bin: '{255, 256, 256}, re: '{-32768, 30000, 30000}, im: '{-32768, 30000, 30000},
                   bg_re: 1, bg_im: 0, exp_bin: 255, exp_mag: 65534};
        tbl[4] = '{bin: '{0, 0, 0}, re: '{0, 0, 0}, im: '{0, 0, 0},
                   bg_re: 0, bg_im: 0, exp_bin: 1, exp_mag: 0};

        @(negedge clk);
        chk("rst_ready", sample_ready, 0);
        chk("rst_load", load, 0);
        chk("rst_addr", load_address, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_start", start, 0);
        chk("rst_peak", {peak_bin, peak_mag}, 0);
        chk("rst_result_valid", result_valid, 0);
        rst = 1'b0;
        #1;
        chk("ready_before_first_edge", sample_ready, 0);

        // Partial load of 100 samples, then reset mid-frame
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in = 16'(i);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        chk("partial_addr", load_address, 100);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_load", load, 0);
        chk("async_rst_addr", load_address, 0);
        chk("async_rst_ready", sample_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        run_frame(tbl[0], 1'b1, N);
        for (int t = 1; t < 5; t++)
            run_frame(tbl[t], 1'b0, N);

        run_frame(tbl[0], 1'b0, 200);
        run_frame(tbl[1], 1'b0, N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Drives the load/start side of the FFT control block and consumes its done/data_out stream; the opposite end of the FFT interface from the core itself. It packs a stream of 16-bit audio samples into one N-point frame, loads it and pulses start. It then reads the bins back and reports the peak-magnitude bin for the tuner display logic. Frames repeat continuously.

Parameters:
N, 512, FFT length (power of two, >= 8)
ADDR_W, 9, log2(N); width of load_address and bin indices
MIN_BIN, 1, lowest bin eligible for peak search (excludes DC)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_in  in  16  signed audio sample
sample_valid  in  1  sample_in is valid this cycle
sample_ready  out  1  block accepts a sample this cycle
load  out  1  to FFT: load phase active
load_address  out  ADDR_W  to FFT: sample slot being written
data_in  out  32  to FFT: {re[31:16], im[15:0]}
start  out  1  to FFT: one-cycle start pulse
done  in  1  from FFT: data_out carries a valid bin
data_out  in  32  from FFT: {re, im} of current bin
peak_bin  out  ADDR_W  index of largest-magnitude bin in last frame
peak_mag  out  17  magnitude of that bin (see Optional Feature)
result_valid  out  1  one-cycle pulse when peak_bin/peak_mag update

Behaviour:
- Reset values: sample_ready=0, load=0, load_address=0, data_in=0, start=0, peak_bin=0, peak_mag=0, result_valid=0. State is LOAD on the first edge after reset release.
- States: LOAD -> START -> WAIT -> DRAIN -> REPORT -> LOAD.
- LOAD: load=1, sample_ready=1. data_in = {sample_in, 16'h0000} combinationally. load_address = sample counter.
  - A transfer occurs when sample_valid & sample_ready. Only on a transfer does the counter increment.
  - FFT latches on clk edges with load=1, so load_address/data_in are held while sample_valid=0.
  - After the transfer at address N-1, go to START. Counter wraps to 0.
- START: exactly one cycle. load=0, start=1, sample_ready=0. Then go to WAIT.
- WAIT: all outputs to the FFT are low. Stay until done=1, then enter DRAIN. That same cycle is bin 0.
- DRAIN: consume one bin per cycle while done=1; bin index counts 0..N-1.
  - Magnitude = |re| + |im|, each abs saturated (-32768 -> 32767), giving a 17-bit unsigned value.
  - Only bins MIN_BIN..N/2-1 compete for peak. Replace the running peak only on strictly greater magnitude, so ties keep the lower bin.
  - The running peak is initialised to bin MIN_BIN, magnitude 0, at DRAIN entry.
  - After bin N-1 is consumed, go to REPORT.
  - If done falls before N bins: abort to LOAD. No result_valid; peak outputs keep old values.
- REPORT: one cycle. Register peak_bin/peak_mag and pulse result_valid=1, then go to LOAD.
- Samples offered outside LOAD are not accepted (sample_ready=0). The upstream source must hold or drop them.
- Asynchronous reset mid-frame discards the partial frame and forces all reset values immediately.
- Latency: result_valid asserts exactly 1 cycle after the last done cycle.

Optional Feature:
MAG_SQUARED_EN
- Defined: magnitude = re*re + im*im (signed 16x16 squares, summed unsigned). peak_mag widens to 33 bits via a package constant MAG_W. Squaring is pipelined one stage, so REPORT occurs 2 cycles after the last done cycle.
- Undefined: |re|+|im| L1 approximation, MAG_W=17, 1-cycle latency as above.

Decomposition:
- Package fft_seq_pkg holds:
  - state enum (LOAD, START, WAIT, DRAIN, REPORT)
  - MAG_W constant (conditional on MAG_SQUARED_EN)
  - complex_t packed struct {logic signed [15:0] re, im}
- Sub-module fft_bin_mag: combinational/pipelined magnitude of one complex_t. The two implementations are selected by the macro.

Test Plan:
- Reset mid-LOAD after 100 samples, release -> load_address=0, sample_ready=1, no start until 512 new samples.
- Stream 512 samples with sample_valid toggling every other cycle -> load_address advances only on transfers; start pulses exactly once, one cycle after address 511 accepted.
- FFT model returns bin 37 = (1000, -500), all others (10, 10) -> peak_bin=37, peak_mag=1500, result_valid one cycle after bin 511.
- Bins 20 and 40 both = (300, 0), others 0 -> peak_bin=20 (tie keeps lower).
- Bin 0 = (32767, 32767), bin 300 = (-32768, 0), bin 5 = (100, 0) -> peak_bin=5, peak_mag=100. Confirms bin 0 (DC) and bins >= N/2 are excluded, and exercises saturated abs.
- done drops after 200 bins -> no result_valid, peak outputs unchanged, block returns to LOAD (sample_ready=1).
